// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg: shared types and defaults for the PLL lock sequencer.
// Holds the state encoding, default parameters and the loss saturation limit.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    ST_ASSERT_RST = 3'd0,
    ST_WAIT_LOCK  = 3'd1,
    ST_STABLE     = 3'd2,
    ST_RUN        = 3'd3,
    ST_FAULT      = 3'd4
  } pll_state_e;

  localparam int DEF_RST_PULSE_CYCLES    = 16;
  localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 65536;
  localparam int DEF_MAX_ATTEMPTS        = 3;

  localparam logic [7:0] LOSS_SAT = 8'd255;

  // Counter width sized to hold the parameter value itself.
  function automatic int cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: 1-bit two-flop synchronizer, synchronous active-low reset to 0.
// Ports: clk, reset_n, d (async input), q (synchronized output).
module sync_2ff (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: PLL reset pulse, lock qualification, timeout/retry,
// lock-loss recovery and fault handling for one PLL.
// Ports: clk, reset_n (sync, active-low), pll_locked (async), req_relock,
// pll_rst, sys_reset_n, fault, lock_loss_count[7:0], state[2:0].
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_PULSE_CYCLES    = DEF_RST_PULSE_CYCLES,
  parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int MAX_ATTEMPTS        = DEF_MAX_ATTEMPTS
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic       req_relock,
  output logic       pll_rst,
  output logic       sys_reset_n,
  output logic       fault,
  output logic [7:0] lock_loss_count,
  output logic [2:0] state
);

  localparam int RW = cnt_w(RST_PULSE_CYCLES);
  localparam int SW = cnt_w(LOCK_STABLE_CYCLES);
  localparam int TW = cnt_w(LOCK_TIMEOUT_CYCLES);
  localparam int AW = cnt_w(MAX_ATTEMPTS);

  localparam logic [RW-1:0] RST_LAST = RW'(RST_PULSE_CYCLES - 1);
  localparam logic [SW-1:0] STB_LAST = SW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [AW-1:0] ATT_MAX  = AW'(MAX_ATTEMPTS);

  pll_state_e    st;
  logic          locked_s;
  logic [RW-1:0] rst_cnt;
  logic [SW-1:0] stable_cnt;
  logic [TW-1:0] to_cnt;
  logic [AW-1:0] attempt_cnt;
  logic          to_hit;
  logic          tries_done;

  sync_2ff u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (pll_locked),
    .q       (locked_s)
  );

  // to_cnt holds the cycles already spent in this attempt, so the
  // compare fires on the last allowed WAIT_LOCK/STABLE cycle.
  assign to_hit     = (to_cnt == TO_LAST);
  assign tries_done = (attempt_cnt >= ATT_MAX);
  assign state      = st;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      st              <= ST_ASSERT_RST;
      pll_rst         <= 1'b1;
      sys_reset_n     <= 1'b0;
      fault           <= 1'b0;
      lock_loss_count <= '0;
      attempt_cnt     <= '0;
      rst_cnt         <= '0;
      stable_cnt      <= '0;
      to_cnt          <= '0;
    end else begin
      unique case (st)
        ST_ASSERT_RST: begin
          to_cnt     <= '0;
          stable_cnt <= '0;
          // First pulse cycle opens a new attempt.
          if (rst_cnt == '0) begin
            attempt_cnt <= attempt_cnt + 1'b1;
          end
          if (rst_cnt == RST_LAST) begin
            rst_cnt <= '0;
            pll_rst <= 1'b0;
            st      <= ST_WAIT_LOCK;
          end else begin
            rst_cnt <= rst_cnt + 1'b1;
          end
        end

        ST_WAIT_LOCK: begin
          if (to_hit) begin
            to_cnt  <= '0;
            pll_rst <= 1'b1;
            if (tries_done) begin
              st    <= ST_FAULT;
              fault <= 1'b1;
            end else begin
              st <= ST_ASSERT_RST;
            end
          end else begin
            to_cnt <= to_cnt + 1'b1;
            if (locked_s) begin
              st         <= ST_STABLE;
              stable_cnt <= '0;
            end
          end
        end

        ST_STABLE: begin
          // stable_cnt is the streak minus one; completion wins
          // over a timeout landing on the same cycle.
          if (locked_s && stable_cnt == STB_LAST) begin
            st          <= ST_RUN;
            sys_reset_n <= 1'b1;
            attempt_cnt <= '0;
            stable_cnt  <= '0;
            to_cnt      <= '0;
          end else if (to_hit) begin
            to_cnt     <= '0;
            stable_cnt <= '0;
            pll_rst    <= 1'b1;
            if (tries_done) begin
              st    <= ST_FAULT;
              fault <= 1'b1;
            end else begin
              st <= ST_ASSERT_RST;
            end
          end else begin
            to_cnt <= to_cnt + 1'b1;
            if (locked_s) begin
              stable_cnt <= stable_cnt + 1'b1;
            end else begin
              stable_cnt <= '0;
              st         <= ST_WAIT_LOCK;
            end
          end
        end

        ST_RUN: begin
          // A relock landing with a lock loss is one event.
          if (!locked_s || req_relock) begin
            st          <= ST_ASSERT_RST;
            pll_rst     <= 1'b1;
            sys_reset_n <= 1'b0;
            if (!locked_s && lock_loss_count != LOSS_SAT) begin
              lock_loss_count <= lock_loss_count + 8'd1;
            end
          end
        end

        ST_FAULT: begin
          if (req_relock) begin
            attempt_cnt <= '0;
            fault       <= 1'b0;
            st          <= ST_ASSERT_RST;
          end
        end

        default: begin
          st          <= ST_ASSERT_RST;
          pll_rst     <= 1'b1;
          sys_reset_n <= 1'b0;
          fault       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb_pll_lock_sequencer: directed scenarios plus randomized run against
// a behavioural model of the lock sequencer.
module tb_pll_lock_sequencer;

  localparam int RSTP = 4;
  localparam int STB  = 8;
  localparam int TO   = 32;
  localparam int MAXA = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic       req_relock = 1'b0;
  logic       pll_rst;
  logic       sys_reset_n;
  logic       fault;
  logic [7:0] lock_loss_count;
  logic [2:0] state;

  int n_checks = 0;
  int n_fail = 0;
  int exp_loss = 0;

  // Model: phase 0..4 as named by the interface encoding.
  int   m_phase = 0;
  int   m_len = 0;
  int   m_elapsed = 0;
  int   m_streak = 0;
  int   m_attempt = 0;
  int   m_losses = 0;
  logic m_meta = 1'b0;
  logic m_q = 1'b0;

  pll_lock_sequencer #(
    .RST_PULSE_CYCLES    (RSTP),
    .LOCK_STABLE_CYCLES  (STB),
    .LOCK_TIMEOUT_CYCLES (TO),
    .MAX_ATTEMPTS        (MAXA)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .pll_locked      (pll_locked),
    .req_relock      (req_relock),
    .pll_rst         (pll_rst),
    .sys_reset_n     (sys_reset_n),
    .fault           (fault),
    .lock_loss_count (lock_loss_count),
    .state           (state)
  );

  always #5 clk = ~clk;

  function automatic void give_up();
    m_phase = (m_attempt >= MAXA) ? 4 : 0;
    m_len   = 0;
  endfunction

  function automatic void model_step(input logic lk, input logic rq,
                                     input logic rn);
    logic ls;
    ls = m_q;
    if (!rn) begin
      m_phase = 0; m_len = 0; m_elapsed = 0; m_streak = 0;
      m_attempt = 0; m_losses = 0; m_meta = 1'b0; m_q = 1'b0;
      return;
    end
    case (m_phase)
      0: begin
        if (m_len == 0) m_attempt++;
        m_len++;
        if (m_len == RSTP) begin
          m_phase = 1; m_len = 0; m_elapsed = 0;
        end
      end
      1: begin
        m_elapsed++;
        if (m_elapsed >= TO) give_up();
        else if (ls) begin m_phase = 2; m_streak = 0; end
      end
      2: begin
        if (ls) m_streak++;
        if (ls && m_streak >= STB) begin
          m_phase = 3; m_attempt = 0;
        end else begin
          m_elapsed++;
          if (m_elapsed >= TO) give_up();
          else if (!ls) m_phase = 1;
        end
      end
      3: begin
        if (!ls || rq) begin
          if (!ls && m_losses < 255) m_losses++;
          m_phase = 0; m_len = 0; m_elapsed = 0;
        end
      end
      default: begin
        if (rq) begin
          m_attempt = 0; m_phase = 0; m_len = 0; m_elapsed = 0;
        end
      end
    endcase
    m_q = m_meta;
    m_meta = lk;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step(pll_locked, req_relock, reset_n);
    #1;
  endtask

  task automatic ticks_while_rst(output int n);
    n = 0;
    while (pll_rst === 1'b1 && n < 200) begin tick(); n++; end
    if (pll_rst === 1'b1) n = -1;
  endtask

  task automatic ticks_while_state(input logic [2:0] s, output int n);
    n = 0;
    while (state === s && n < 400) begin tick(); n++; end
    if (state === s) n = -1;
  endtask

  task automatic ticks_until_state(input logic [2:0] s, output int n);
    n = 0;
    while (state !== s && n < 400) begin tick(); n++; end
    if (state !== s) n = -1;
  endtask

  task automatic ticks_until_sys(input logic v, output int n);
    n = 0;
    while (sys_reset_n !== v && n < 400) begin tick(); n++; end
    if (sys_reset_n !== v) n = -1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; pll_locked = 1'b0; req_relock = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (state !== 3'd0) begin
      n_fail++; $display("FAIL reset_state: got %0d want 0", state);
    end
    n_checks++;
    if (pll_rst !== 1'b1) begin
      n_fail++; $display("FAIL reset_pll_rst: got %b want 1", pll_rst);
    end
    n_checks++;
    if (sys_reset_n !== 1'b0 || fault !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_sys_fault: got %b/%b want 0/0",
               sys_reset_n, fault);
    end
    n_checks++;
    if (lock_loss_count !== 8'd0) begin
      n_fail++; $display("FAIL reset_count: got %0d want 0", lock_loss_count);
    end
  endtask

  task automatic test_bring_up();
    int n;
    reset_n = 1'b1;
    ticks_while_rst(n);
    n_checks++;
    if (n != RSTP) begin
      n_fail++; $display("FAIL bringup_pulse: got %0d want %0d", n, RSTP);
    end
    repeat (10) tick();
    pll_locked = 1'b1;
    ticks_until_state(3'd2, n);
    n_checks++;
    if (n < 2 || n > 3) begin
      n_fail++; $display("FAIL bringup_stable_delay: got %0d want 2..3", n);
    end
    ticks_until_sys(1'b1, n);
    n_checks++;
    if (n != STB) begin
      n_fail++; $display("FAIL bringup_release: got %0d want %0d", n, STB);
    end
    n_checks++;
    if (state !== 3'd3 || fault !== 1'b0 || lock_loss_count !== 8'd0) begin
      n_fail++;
      $display("FAIL bringup_run: got st=%0d f=%b c=%0d want 3/0/0",
               state, fault, lock_loss_count);
    end
  endtask

  task automatic test_glitch();
    int n;
    int entry;
    int done;
    bit saw_wait;
    bit saw_rst;
    logic [2:0] prev;
    req_relock = 1'b1; tick(); req_relock = 1'b0;
    n_checks++;
    if (state !== 3'd0 || lock_loss_count !== 8'd0) begin
      n_fail++;
      $display("FAIL relock_run: got st=%0d c=%0d want 0/0",
               state, lock_loss_count);
    end
    ticks_while_rst(n);
    n_checks++;
    if (n != RSTP) begin
      n_fail++; $display("FAIL relock_pulse: got %0d want %0d", n, RSTP);
    end
    ticks_until_state(3'd2, n);
    entry = 0; done = -1; saw_wait = 0; saw_rst = 0; prev = 3'd2;
    for (int t = 1; t <= 80; t++) begin
      pll_locked = !(t >= 5 && t <= 7);
      tick();
      if (state === 3'd1 && sys_reset_n === 1'b0) saw_wait = 1;
      if (pll_rst === 1'b1) saw_rst = 1;
      if (state === 3'd2 && prev !== 3'd2) entry = t;
      if (sys_reset_n === 1'b1) begin done = t; break; end
      prev = state;
    end
    n_checks++;
    if (!saw_wait) begin
      n_fail++; $display("FAIL glitch_wait: got none want WAIT_LOCK");
    end
    n_checks++;
    if (saw_rst) begin
      n_fail++; $display("FAIL glitch_no_pulse: got pll_rst=1 want 0");
    end
    n_checks++;
    if (done < 0 || done - entry != STB) begin
      n_fail++;
      $display("FAIL glitch_fresh: got %0d want %0d", done - entry, STB);
    end
  endtask

  task automatic test_lock_loss();
    int n;
    pll_locked = 1'b0;
    ticks_until_sys(1'b0, n);
    exp_loss = 1;
    n_checks++;
    if (n < 1 || n > 3) begin
      n_fail++; $display("FAIL loss_drop: got %0d want 1..3", n);
    end
    n_checks++;
    if (lock_loss_count !== 8'(exp_loss) || state !== 3'd0) begin
      n_fail++;
      $display("FAIL loss_count: got c=%0d st=%0d want %0d/0",
               lock_loss_count, state, exp_loss);
    end
  endtask

  task automatic test_timeout();
    int n;
    for (int k = 0; k < 2; k++) begin
      ticks_while_rst(n);
      n_checks++;
      if (n != RSTP) begin
        n_fail++; $display("FAIL timeout_pulse%0d: got %0d want %0d", k, n, RSTP);
      end
      ticks_while_state(3'd1, n);
      n_checks++;
      if (n != TO) begin
        n_fail++; $display("FAIL timeout_wait%0d: got %0d want %0d", k, n, TO);
      end
    end
    n_checks++;
    if (state !== 3'd4 || fault !== 1'b1 || pll_rst !== 1'b1 ||
        sys_reset_n !== 1'b0) begin
      n_fail++;
      $display("FAIL fault_entry: got st=%0d f=%b r=%b s=%b want 4/1/1/0",
               state, fault, pll_rst, sys_reset_n);
    end
    repeat (5) tick();
    n_checks++;
    if (state !== 3'd4) begin
      n_fail++; $display("FAIL fault_hold: got %0d want 4", state);
    end
    req_relock = 1'b1; tick(); req_relock = 1'b0;
    n_checks++;
    if (fault !== 1'b0 || state !== 3'd0) begin
      n_fail++;
      $display("FAIL fault_exit: got f=%b st=%0d want 0/0", fault, state);
    end
    ticks_while_rst(n);
    n_checks++;
    if (n != RSTP) begin
      n_fail++; $display("FAIL fault_pulse: got %0d want %0d", n, RSTP);
    end
    pll_locked = 1'b1;
    ticks_until_state(3'd3, n);
    n_checks++;
    if (n < 0) begin
      n_fail++; $display("FAIL fault_recover: got st=%0d want 3", state);
    end
  endtask

  task automatic test_same_cycle();
    int n;
    int extra;
    pll_locked = 1'b0;
    tick(); tick();
    req_relock = 1'b1; tick(); req_relock = 1'b0;
    exp_loss++;
    n_checks++;
    if (state !== 3'd0 || lock_loss_count !== 8'(exp_loss)) begin
      n_fail++;
      $display("FAIL same_cycle_count: got st=%0d c=%0d want 0/%0d",
               state, lock_loss_count, exp_loss);
    end
    pll_locked = 1'b1;
    ticks_while_rst(n);
    n_checks++;
    if (n != RSTP) begin
      n_fail++; $display("FAIL same_cycle_pulse: got %0d want %0d", n, RSTP);
    end
    extra = 0;
    repeat (30) begin tick(); if (pll_rst === 1'b1) extra++; end
    n_checks++;
    if (extra != 0 || state !== 3'd3 || lock_loss_count !== 8'(exp_loss)) begin
      n_fail++;
      $display("FAIL same_cycle_single: got extra=%0d st=%0d c=%0d want 0/3/%0d",
               extra, state, lock_loss_count, exp_loss);
    end
  endtask

  task automatic test_saturation();
    int n;
    bit stuck;
    stuck = 0;
    for (int i = 0; i < 257; i++) begin
      pll_locked = 1'b0;
      ticks_until_state(3'd0, n);
      if (n < 0) stuck = 1;
      if (exp_loss < 255) exp_loss++;
      pll_locked = 1'b1;
      ticks_until_state(3'd3, n);
      if (n < 0) stuck = 1;
      if (stuck) break;
      if (i == 100) begin
        n_checks++;
        if (lock_loss_count !== 8'(exp_loss)) begin
          n_fail++;
          $display("FAIL sat_mid: got %0d want %0d", lock_loss_count, exp_loss);
        end
      end
    end
    n_checks++;
    if (stuck) begin
      n_fail++; $display("FAIL sat_progress: got stuck want RUN each loop");
    end
    n_checks++;
    if (lock_loss_count !== 8'd255) begin
      n_fail++; $display("FAIL sat_final: got %0d want 255", lock_loss_count);
    end
  endtask

  task automatic test_reset_mid_stable();
    int n;
    req_relock = 1'b1; tick(); req_relock = 1'b0;
    ticks_until_state(3'd2, n);
    repeat (3) tick();
    n_checks++;
    if (state !== 3'd2) begin
      n_fail++; $display("FAIL mid_pre: got %0d want 2", state);
    end
    reset_n = 1'b0; tick();
    n_checks++;
    if (state !== 3'd0 || pll_rst !== 1'b1 || sys_reset_n !== 1'b0 ||
        fault !== 1'b0 || lock_loss_count !== 8'd0) begin
      n_fail++;
      $display("FAIL mid_reset: got st=%0d r=%b s=%b f=%b c=%0d want 0/1/0/0/0",
               state, pll_rst, sys_reset_n, fault, lock_loss_count);
    end
    exp_loss = 0;
    reset_n = 1'b1;
    ticks_while_rst(n);
    n_checks++;
    if (n != RSTP) begin
      n_fail++; $display("FAIL mid_pulse: got %0d want %0d", n, RSTP);
    end
    ticks_until_state(3'd3, n);
    n_checks++;
    if (n < 0 || lock_loss_count !== 8'd0) begin
      n_fail++;
      $display("FAIL mid_recover: got st=%0d c=%0d want 3/0",
               state, lock_loss_count);
    end
  endtask

  task automatic test_random();
    int run_left;
    int bad;
    logic [2:0] e_st;
    logic [7:0] e_cnt;
    logic e_rst;
    logic e_sys;
    logic e_f;
    run_left = 0; bad = 0;
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    for (int c = 0; c < 4000 && bad < 10; c++) begin
      if (run_left == 0) begin
        pll_locked = ($urandom_range(0, 9) < 7);
        run_left = $urandom_range(1, 40);
      end
      run_left--;
      req_relock = ($urandom_range(0, 39) == 0);
      reset_n = ($urandom_range(0, 499) != 0);
      tick();
      e_st  = 3'(m_phase);
      e_rst = (m_phase == 0 || m_phase == 4);
      e_sys = (m_phase == 3);
      e_f   = (m_phase == 4);
      e_cnt = 8'(m_losses);
      n_checks++;
      if (state !== e_st || pll_rst !== e_rst || sys_reset_n !== e_sys ||
          fault !== e_f || lock_loss_count !== e_cnt) begin
        n_fail++; bad++;
        $display("FAIL random_cycle%0d: got st=%0d r=%b s=%b f=%b c=%0d want %0d/%b/%b/%b/%0d",
                 c, state, pll_rst, sys_reset_n, fault, lock_loss_count,
                 e_st, e_rst, e_sys, e_f, e_cnt);
      end
    end
    req_relock = 1'b0;
    reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_bring_up();
    test_glitch();
    test_lock_loss();
    test_timeout();
    test_same_cycle();
    test_saturation();
    test_reset_mid_stable();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pll_lock_sequencer.md
PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

Interface
REQ-001 Parameter RST_PULSE_CYCLES, default 16: length of the PLL reset pulse, in clk cycles.
REQ-002 Parameter LOCK_STABLE_CYCLES, default 1024: consecutive synchronized-lock cycles required before release.
REQ-003 Parameter LOCK_TIMEOUT_CYCLES, default 65536: cycles allowed per attempt from pll_rst deassertion to RUN.
REQ-004 Parameter MAX_ATTEMPTS, default 3: bring-up attempts allowed before FAULT.
REQ-005 clk  input  1  free-running reference clock, the same 50 MHz source that drives the PLL refclk.
REQ-006 reset_n  input  1  synchronous, active-low reset.
REQ-007 pll_locked  input  1  PLL locked flag; asynchronous to clk.
REQ-008 req_relock  input  1  single-cycle software request to re-run bring-up.
REQ-009 pll_rst  output  1  active-high reset, wired to the PLL rst input.
REQ-010 sys_reset_n  output  1  active-low reset for logic in the PLL output domains; high only in RUN.
REQ-011 fault  output  1  high while in FAULT.
REQ-012 lock_loss_count  output  8  saturating count of lock losses seen in RUN.
REQ-013 state  output  3  encoding: ASSERT_RST=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAULT=4.

Function
REQ-014 pll_locked shall pass through a 2-flop synchronizer; all decisions use the synchronized value (locked_s).
REQ-015 ASSERT_RST: pll_rst=1 for exactly RST_PULSE_CYCLES cycles, then go to WAIT_LOCK.
- Entering ASSERT_RST increments attempt_cnt.
- Entering ASSERT_RST clears the timeout counter.
REQ-016 WAIT_LOCK: pll_rst=0; go to STABLE on the first cycle locked_s=1.
REQ-017 STABLE: count consecutive locked_s=1 cycles.
- Entry cycle counts as 1.
- Go to RUN when the count reaches LOCK_STABLE_CYCLES.
- locked_s=0 returns to WAIT_LOCK and clears the count.
REQ-018 The timeout counter shall run in both WAIT_LOCK and STABLE and shall not be cleared by lock glitches.
- At LOCK_TIMEOUT_CYCLES with attempt_cnt<MAX_ATTEMPTS: go to ASSERT_RST.
- At LOCK_TIMEOUT_CYCLES with attempt_cnt=MAX_ATTEMPTS: go to FAULT.
REQ-019 RUN: sys_reset_n=1; entering RUN clears attempt_cnt.
- locked_s=0: go to ASSERT_RST and increment lock_loss_count, saturating at 255.
- req_relock=1: go to ASSERT_RST without incrementing the count.
REQ-020 lock_s=0 and req_relock=1 in the same RUN cycle shall count as exactly one lock loss and produce one reset pulse.
REQ-021 FAULT: pll_rst=1, sys_reset_n=0, fault=1.
- Exit only on req_relock: clear attempt_cnt, then go to ASSERT_RST.
REQ-022 req_relock shall be ignored in ASSERT_RST, WAIT_LOCK and STABLE.
REQ-023 sys_reset_n shall be registered (=state is RUN).
- It falls the cycle after RUN is left.
- Worst-case drop after pll_locked falls: 3 clk cycles.
REQ-024 pll_rst shall be registered and glitch-free.
REQ-025 Counter widths shall be $clog2 of their parameter +1; parameters of 1 shall be legal.

Reset
REQ-026 reset_n=0 at a clk edge forces the following values on the next cycle, from any state, including mid-operation:
- state=ASSERT_RST, pll_rst=1, sys_reset_n=0, fault=0.
- lock_loss_count=0, attempt_cnt=0.
- All counters and synchronizer flops cleared.
REQ-027 After reset_n rises, the ASSERT_RST pulse counts from its first cycle as attempt 1.

Structure
REQ-028 Package pll_seq_pkg shall hold:
- the state typedef and encoding;
- the default parameter constants;
- the saturation limit constant, 255.
REQ-029 Sub-module sync_2ff (1-bit, reset to 0) shall implement the synchronizer; all other logic stays in one FSM plus counters.

Verification (RST_PULSE=4, LOCK_STABLE=8, LOCK_TIMEOUT=32, MAX_ATTEMPTS=2)
REQ-030 Normal bring-up: pll_locked rises 10 cycles after pll_rst falls and stays high.
- pll_rst high exactly 4 cycles.
- STABLE entered 2-3 cycles after the rise; sys_reset_n rises 8 cycles after STABLE entry.
- fault=0, lock_loss_count=0.
REQ-031 Glitch: pll_locked low 3 cycles at STABLE count 5.
- Returns to WAIT_LOCK with sys_reset_n=0.
- Needs a full 8 fresh cycles; no new pll_rst pulse if still inside the timeout.
REQ-032 Timeout: pll_locked held 0.
- Two pll_rst pulses of 4 cycles, each followed by 32 WAIT_LOCK cycles, then fault=1, state=4, pll_rst=1.
- req_relock: fault=0 and a new 4-cycle pulse.
REQ-033 Lock loss in RUN: drop pll_locked.
- sys_reset_n=0 within 3 cycles, lock_loss_count=1, bring-up restarts.
- After 257 forced losses the count reads 255.
REQ-034 Same-cycle req_relock and locked_s fall in RUN: count increments by exactly 1, single 4-cycle pll_rst pulse.
REQ-035 reset_n=0 mid-STABLE: on the next cycle every output and internal counter holds its REQ-026 value.
